utm_tape_sequencer: RTL and testbench

Drives the Turing-machine transition-table user module from the other side of its interface: holds the tape, head position and current state, and presents {state, symbol} to the table. It captures {next_state, new_sym, move}, writes the tape, moves the head and iterates until the halt state, a tape-edge fault or a step limit. It sits beside the combinational transition table in the same design.

---
 rtl/utm_tape_sequencer_if.sv | 28 ++
 rtl/utm_tape_sequencer.sv | 155 +++++++++++++++
 tb/tb_utm_tape_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/utm_tape_sequencer_if.sv
// Transition-table link: the sequencer presents {state, symbol},
// the combinational table answers with {next_state, new_sym, move}.
interface utm_tape_sequencer_if #(
    parameter int SYM_W   = 3,
    parameter int STATE_W = 3
);
    logic [STATE_W-1:0] tbl_state;
    logic [SYM_W-1:0]   tbl_sym;
    logic [STATE_W-1:0] tbl_next_state;
    logic [SYM_W-1:0]   tbl_new_sym;
    logic [1:0]         tbl_move;

    modport master (
        output tbl_state,
        output tbl_sym,
        input  tbl_next_state,
        input  tbl_new_sym,
        input  tbl_move
    );

    modport slave (
        input  tbl_state,
        input  tbl_sym,
        output tbl_next_state,
        output tbl_new_sym,
        output tbl_move
    );
endinterface

// File: rtl/utm_tape_sequencer.sv
// Turing-machine tape sequencer: owns tape, head and state, and steps the
// external transition table until halt, a tape-edge fault or the step limit.
module utm_tape_sequencer #(
    parameter int TAPE_LEN    = 16,
    parameter int SYM_W       = 3,
    parameter int STATE_W     = 3,
    parameter int START_STATE = 0,
    parameter int HALT_STATE  = 7,
    parameter int HEAD_INIT   = 0,
    parameter int MAX_STEPS   = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        load_en,
    input  logic [$clog2(TAPE_LEN)-1:0] load_addr,
    input  logic [SYM_W-1:0]            load_sym,
    input  logic [$clog2(TAPE_LEN)-1:0] rd_addr,
    output logic [SYM_W-1:0]            rd_sym,
    utm_tape_sequencer_if.master        tbl,
    output logic [$clog2(TAPE_LEN)-1:0] head_pos,
    output logic                        running,
    output logic                        halted,
    output logic [1:0]                  fault,
    output logic [15:0]                 step_count
);
    localparam int AW = $clog2(TAPE_LEN);

    localparam logic [AW-1:0]      HEAD_RST  = AW'(HEAD_INIT);
    localparam logic [AW-1:0]      HEAD_LAST = AW'(TAPE_LEN - 1);
    localparam logic [STATE_W-1:0] ST_START  = STATE_W'(START_STATE);
    localparam logic [STATE_W-1:0] ST_HALT   = STATE_W'(HALT_STATE);
    localparam logic [15:0]        STEP_MAX  = 16'(MAX_STEPS);

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_LEFT  = 2'b01;
    localparam logic [1:0] F_RIGHT = 2'b10;
    localparam logic [1:0] F_TIME  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALTED,
        FAULT
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [SYM_W-1:0]   tape_q [TAPE_LEN];
    logic [SYM_W-1:0]   tape_d [TAPE_LEN];
    logic [STATE_W-1:0] st_q, st_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [AW-1:0]      head_q, head_d;
    logic [15:0]        steps_q, steps_d;
    logic [1:0]         fault_q, fault_d;
    logic               running_q, running_d;
    logic               halted_q, halted_d;

    logic               edge_l;
    logic               edge_r;

    always_comb begin
        edge_l = (tbl.tbl_move == 2'b10) && (head_q == '0);
        edge_r = (tbl.tbl_move == 2'b01) && (head_q == HEAD_LAST);
    end

    always_comb begin
        fsm_d   = fsm_q;
        tape_d  = tape_q;
        st_d    = st_q;
        sym_d   = sym_q;
        head_d  = head_q;
        steps_d = steps_q;
        fault_d = fault_q;
        unique case (fsm_q)
            IDLE, HALTED, FAULT: begin
                // Loads land in the same edge as start so FETCH sees them.
                if (load_en) begin
                    tape_d[load_addr] = load_sym;
                end
                if (start) begin
                    head_d  = HEAD_RST;
                    st_d    = ST_START;
                    steps_d = '0;
                    fault_d = F_NONE;
                    fsm_d   = FETCH;
                end
            end
            FETCH: begin
                sym_d = tape_q[head_q];
                fsm_d = (st_q == ST_HALT) ? HALTED : EXEC;
            end
            EXEC: begin
                tape_d[head_q] = tbl.tbl_new_sym;
                st_d           = tbl.tbl_next_state;
                steps_d        = steps_q + 16'd1;
                fsm_d          = FETCH;
                if (edge_l) begin
                    fault_d = F_LEFT;
                    fsm_d   = FAULT;
                end else if (edge_r) begin
                    fault_d = F_RIGHT;
                    fsm_d   = FAULT;
                end else begin
                    unique case (tbl.tbl_move)
                        2'b01:   head_d = head_q + 1'b1;
                        2'b10:   head_d = head_q - 1'b1;
                        default: head_d = head_q;
                    endcase
                    if (steps_d == STEP_MAX &&
                        tbl.tbl_next_state != ST_HALT) begin
                        fault_d = F_TIME;
                        fsm_d   = FAULT;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
        running_d = (fsm_d == FETCH) || (fsm_d == EXEC);
        halted_d  = (fsm_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= IDLE;
            tape_q    <= '{default: '0};
            st_q      <= ST_START;
            sym_q     <= '0;
            head_q    <= HEAD_RST;
            steps_q   <= '0;
            fault_q   <= F_NONE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            tape_q    <= tape_d;
            st_q      <= st_d;
            sym_q     <= sym_d;
            head_q    <= head_d;
            steps_q   <= steps_d;
            fault_q   <= fault_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    assign rd_sym        = tape_q[rd_addr];
    assign tbl.tbl_state = st_q;
    assign tbl.tbl_sym   = sym_q;
    assign head_pos      = head_q;
    assign running       = running_q;
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign step_count    = steps_q;
endmodule

// File: tb/tb_utm_tape_sequencer.sv
// Bench for utm_tape_sequencer: a shared table model drives two instances
// (short step limit, and head starting at the right edge); runs are scoreboarded.
module tb_utm_tape_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 0, start_b = 0;
    logic       load_en_a = 0, load_en_b = 0;
    logic [3:0] load_addr = 0;
    logic [2:0] load_sym = 0;
    logic [3:0] rd_addr = 0;

    logic [2:0]  rd_sym_a, rd_sym_b;
    logic [3:0]  head_a, head_b;
    logic        running_a, running_b, halted_a, halted_b;
    logic [1:0]  fault_a, fault_b;
    logic [15:0] steps_a, steps_b;

    logic [7:0] tbl_mem [64];

    utm_tape_sequencer_if #(.SYM_W(3), .STATE_W(3)) if_a ();
    utm_tape_sequencer_if #(.SYM_W(3), .STATE_W(3)) if_b ();

    assign {if_a.tbl_next_state, if_a.tbl_new_sym, if_a.tbl_move} =
        tbl_mem[{if_a.tbl_state, if_a.tbl_sym}];
    assign {if_b.tbl_next_state, if_b.tbl_new_sym, if_b.tbl_move} =
        tbl_mem[{if_b.tbl_state, if_b.tbl_sym}];

    utm_tape_sequencer #(.MAX_STEPS(5)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .load_en(load_en_a), .load_addr(load_addr), .load_sym(load_sym),
        .rd_addr(rd_addr), .rd_sym(rd_sym_a), .tbl(if_a.master),
        .head_pos(head_a), .running(running_a), .halted(halted_a),
        .fault(fault_a), .step_count(steps_a)
    );

    utm_tape_sequencer #(.HEAD_INIT(15)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .load_en(load_en_b), .load_addr(load_addr), .load_sym(load_sym),
        .rd_addr(rd_addr), .rd_sym(rd_sym_b), .tbl(if_b.master),
        .head_pos(head_b), .running(running_b), .halted(halted_b),
        .fault(fault_b), .step_count(steps_b)
    );

    typedef struct {
        int          cycles;
        logic        halted;
        logic [1:0]  fault;
        logic [3:0]  head;
        logic [15:0] steps;
        logic [2:0]  st;
        logic [2:0]  first_sym;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(int c, logic h, logic [1:0] f, logic [3:0] hd,
                                logic [15:0] s, logic [2:0] st, logic [2:0] fs);
        exp_t e;
        e.cycles = c; e.halted = h; e.fault = f; e.head = hd;
        e.steps = s; e.st = st; e.first_sym = fs;
        return e;
    endfunction

    task automatic set_row(input logic [2:0] st, input logic [2:0] sy,
                           input logic [2:0] nx, input logic [2:0] nw,
                           input logic [1:0] mv);
        tbl_mem[{st, sy}] = {nx, nw, mv};
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 64; i++) tbl_mem[i] = {3'd7, 3'd0, 2'b00};
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic rd_chk(input bit b, input logic [3:0] a,
                          input logic [2:0] exp, input string tag);
        rd_addr = a;
        #1;
        chk(tag, b ? rd_sym_b : rd_sym_a, exp);
    endtask

    task automatic run(input bit b, input bit pre, input logic [3:0] pa,
                       input logic [2:0] ps, input bit busy, input exp_t e);
        int   n;
        bit   done;
        exp_t x;
        sb.push_back(e);
        @(posedge clk); #1;
        if (pre) begin
            load_addr = pa; load_sym = ps;
            if (b) load_en_b = 1; else load_en_a = 1;
        end
        if (b) start_b = 1; else start_a = 1;
        @(posedge clk); #1;
        start_a = 0; start_b = 0; load_en_a = 0; load_en_b = 0;
        chk("go_running", b ? running_b : running_a, 1);
        chk("go_fault", b ? fault_b : fault_a, 0);
        chk("go_steps", b ? steps_b : steps_a, 0);
        if (busy) begin
            load_addr = 4'd2; load_sym = 3'd6; load_en_a = 1;
        end
        n = 0; done = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1)
                chk("first_sym", b ? if_b.tbl_sym : if_a.tbl_sym, e.first_sym);
            if (!(b ? running_b : running_a)) done = 1;
        end
        load_en_a = 0;
        if (!done) begin
            chk("run_bound", 0, 1);
        end else begin
            x = sb.pop_front();
            chk("cycles", n, x.cycles);
            chk("halted", b ? halted_b : halted_a, x.halted);
            chk("fault", b ? fault_b : fault_a, x.fault);
            chk("head", b ? head_b : head_a, x.head);
            chk("steps", b ? steps_b : steps_a, x.steps);
            chk("state", b ? if_b.tbl_state : if_a.tbl_state, x.st);
        end
    endtask

    initial begin
        clear_tbl();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) rd_chk(0, 4'(i), 3'd0, "rst_tape");
        chk("rst_state", if_a.tbl_state, 0);
        chk("rst_head", head_a, 0);
        chk("rst_fault", fault_a, 0);
        chk("rst_halted", halted_a, 0);
        chk("rst_running", running_a, 0);
        chk("rst_head_b", head_b, 15);

        set_row(3'd0, 3'd0, 3'd1, 3'd1, 2'b01);
        set_row(3'd1, 3'd0, 3'd7, 3'd2, 2'b10);
        run(0, 0, 0, 0, 0, mk(5, 1, 2'b00, 0, 2, 3'd7, 3'd0));
        rd_chk(0, 4'd0, 3'd1, "two_t0");
        rd_chk(0, 4'd1, 3'd2, "two_t1");

        do_reset();
        clear_tbl();
        for (int s = 0; s < 8; s++) set_row(3'd0, 3'(s), 3'd0, 3'd3, 2'b10);
        run(0, 0, 0, 0, 0, mk(2, 0, 2'b01, 0, 1, 3'd0, 3'd0));
        rd_chk(0, 4'd0, 3'd3, "left_t0");

        clear_tbl();
        set_row(3'd0, 3'd1, 3'd1, 3'd4, 2'b01);
        run(1, 1, 4'd15, 3'd1, 0, mk(2, 0, 2'b10, 15, 1, 3'd1, 3'd1));
        rd_chk(1, 4'd15, 3'd4, "right_t15");

        do_reset();
        clear_tbl();
        for (int s = 0; s < 8; s++) set_row(3'd0, 3'(s), 3'd0, 3'(s), 2'b00);
        run(0, 0, 0, 0, 1, mk(10, 0, 2'b11, 0, 5, 3'd0, 3'd0));
        rd_chk(0, 4'd2, 3'd0, "busy_load_t2");
        rd_chk(0, 4'd0, 3'd0, "tout_t0");
        run(0, 0, 0, 0, 0, mk(10, 0, 2'b11, 0, 5, 3'd0, 3'd0));

        do_reset();
        clear_tbl();
        set_row(3'd0, 3'd5, 3'd7, 3'd5, 2'b00);
        run(0, 1, 4'd0, 3'd5, 0, mk(3, 1, 2'b00, 0, 1, 3'd7, 3'd5));
        rd_chk(0, 4'd0, 3'd5, "pre_t0");

        do_reset();
        clear_tbl();
        for (int s = 0; s < 8; s++) set_row(3'd0, 3'(s), 3'd0, 3'(s), 2'b00);
        @(posedge clk); #1;
        load_addr = 4'd3; load_sym = 3'd6; load_en_a = 1; start_a = 1;
        @(posedge clk); #1;
        load_en_a = 0; start_a = 0;
        @(posedge clk); #3;
        chk("mid_running", running_a, 1);
        rd_chk(0, 4'd3, 3'd6, "mid_t3");
        reset = 1'b1;
        #1;
        chk("arst_running", running_a, 0);
        chk("arst_tape", rd_sym_a, 0);
        chk("arst_steps", steps_a, 0);
        chk("arst_state", if_a.tbl_state, 0);
        @(negedge clk) reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
